// File: rtl/register_file_vectorial.sv
`default_nettype none
// ============================================================================
// Module      : register_file_vectorial
// Description : Vector register file of REGISTERS entries, each LANES lanes
//               of WIDTH bits. Two combinational read ports, one synchronous
//               write port with a per-lane write mask, optional write-to-read
//               bypass, optional hardwired-zero register 0, and a
//               pending-write scoreboard with a registered pending count.
// Ports       : clk        rising-edge clock
//               rst        synchronous reset, active-low
//               we3        write enable
//               a1, a2     read addresses (ports 1 and 2)
//               a3         write address
//               lane_mask  per-lane write enable (bit i -> lane i)
//               wd3        write data, lane i at [i*WIDTH +: WIDTH]
//               pend_set   mark register pend_addr pending
//               pend_addr  register to mark pending
//               rd1, rd2   read data (ports 1 and 2)
//               busy1/2    pending bit of a1 / a2
//               pend_count number of pending registers
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_vectorial #(
  parameter int REGISTERS = 32,
  parameter int LANES     = 4,
  parameter int WIDTH     = 32,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we3,
  input  logic [$clog2(REGISTERS)-1:0]   a1,
  input  logic [$clog2(REGISTERS)-1:0]   a2,
  input  logic [$clog2(REGISTERS)-1:0]   a3,
  input  logic [LANES-1:0]               lane_mask,
  input  logic [LANES*WIDTH-1:0]         wd3,
  input  logic                           pend_set,
  input  logic [$clog2(REGISTERS)-1:0]   pend_addr,
  output logic [LANES*WIDTH-1:0]         rd1,
  output logic [LANES*WIDTH-1:0]         rd2,
  output logic                           busy1,
  output logic                           busy2,
  output logic [$clog2(REGISTERS):0]     pend_count
);

  localparam int AW = $clog2(REGISTERS);
  localparam int CW = AW + 1;
  localparam int DW = LANES * WIDTH;

  logic [DW-1:0]        r_mem [REGISTERS];
  logic [REGISTERS-1:0] r_pend;
  logic [CW-1:0]        r_count;

  logic                 w_wr_ok;
  logic                 w_set_ok;
  logic [REGISTERS-1:0] w_pend_next;
  logic [CW-1:0]        w_count_next;

  // Register 0 swallows writes and pending marks when it is hardwired to zero.
  assign w_wr_ok  = we3 && !((ZERO_REG != 0) && (a3 == '0));
  assign w_set_ok = pend_set && !((ZERO_REG != 0) && (pend_addr == '0));

  // Clear first, then set: a new producer issued in the same cycle that the
  // previous one retires keeps the register pending.
  always_comb begin
    w_pend_next = r_pend;
    if (we3) begin
      w_pend_next[a3] = 1'b0;
    end
    if (w_set_ok) begin
      w_pend_next[pend_addr] = 1'b1;
    end
  end

  // Count is the popcount of the next pending vector so that it moves in the
  // same edge as the bits themselves and can never drift or wrap.
  always_comb begin
    w_count_next = '0;
    for (int r = 0; r < REGISTERS; r++) begin
      w_count_next = w_count_next + CW'(w_pend_next[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < REGISTERS; r++) begin
        r_mem[r] <= '0;
      end
      r_pend  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) begin
        for (int l = 0; l < LANES; l++) begin
          if (lane_mask[l]) begin
            r_mem[a3][l*WIDTH +: WIDTH] <= wd3[l*WIDTH +: WIDTH];
          end
        end
      end
      r_pend  <= w_pend_next;
      r_count <= w_count_next;
    end
  end

  // Both read ports share one description; port 0 is a1, port 1 is a2.
  generate
    for (genvar p = 0; p < 2; p++) begin : g_rport
      logic [AW-1:0] w_addr;
      logic [DW-1:0] w_data;
      logic          w_busy;

      assign w_addr = (p == 0) ? a1 : a2;

      always_comb begin
        w_data = r_mem[w_addr];
        // Forward only the lanes actually being written; the rest still
        // come from the array.
        if ((BYPASS != 0) && we3 && (w_addr == a3)) begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_mask[l]) begin
              w_data[l*WIDTH +: WIDTH] = wd3[l*WIDTH +: WIDTH];
            end
          end
        end
        if ((ZERO_REG != 0) && (w_addr == '0)) begin
          w_data = '0;
        end
        // Outputs are forced quiet while reset is asserted, not only after
        // the reset edge.
        if (!rst) begin
          w_data = '0;
        end
      end

      // Busy reflects registered state only; a retiring write in this
      // cycle does not clear it early.
      assign w_busy = rst & r_pend[w_addr];
    end
  endgenerate

  assign rd1        = g_rport[0].w_data;
  assign rd2        = g_rport[1].w_data;
  assign busy1      = g_rport[0].w_busy;
  assign busy2      = g_rport[1].w_busy;
  assign pend_count = rst ? r_count : '0;

endmodule
`default_nettype wire

// File: tb/tb_register_file_vectorial.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_vectorial
// Description : Self-checking bench for register_file_vectorial. Two
//               instances share stimulus: u_dut (ZERO_REG=1, BYPASS=1) and
//               u_nb (ZERO_REG=0, BYPASS=0). Directed scenarios use literal
//               expectations; the random scenario compares against a
//               lane-array / pending-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_vectorial;

  logic         clk = 1'b0;
  logic         rst;
  logic         we3;
  logic [4:0]   a1, a2, a3, pend_addr;
  logic [3:0]   lane_mask;
  logic [127:0] wd3;
  logic         pend_set;

  logic [127:0] rd1, rd2, nb_rd1, nb_rd2;
  logic         busy1, busy2, nb_busy1, nb_busy2;
  logic [5:0]   pend_count, nb_pend_count;

  int total = 0;
  int bad   = 0;

  // Reference model: [instance][register][lane], instance 0 = u_dut, 1 = u_nb.
  logic [31:0] mem [2][32][4];
  bit          pnd [2][32];

  always #5 clk = ~clk;

  register_file_vectorial #(
    .REGISTERS(32), .LANES(4), .WIDTH(32), .ZERO_REG(1), .BYPASS(1)
  ) u_dut (
    .clk(clk), .rst(rst), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
    .lane_mask(lane_mask), .wd3(wd3), .pend_set(pend_set), .pend_addr(pend_addr),
    .rd1(rd1), .rd2(rd2), .busy1(busy1), .busy2(busy2), .pend_count(pend_count)
  );

  register_file_vectorial #(
    .REGISTERS(32), .LANES(4), .WIDTH(32), .ZERO_REG(0), .BYPASS(0)
  ) u_nb (
    .clk(clk), .rst(rst), .we3(we3), .a1(a1), .a2(a2), .a3(a3),
    .lane_mask(lane_mask), .wd3(wd3), .pend_set(pend_set), .pend_addr(pend_addr),
    .rd1(nb_rd1), .rd2(nb_rd2), .busy1(nb_busy1), .busy2(nb_busy2),
    .pend_count(nb_pend_count)
  );

  // ---------------- reference model ----------------
  function automatic logic [127:0] exp_rd(int inst, logic [4:0] addr);
    logic [127:0] v;
    logic [31:0]  lane;
    for (int l = 0; l < 4; l++) begin
      lane = mem[inst][addr][l];
      if (inst == 0 && we3 && addr == a3 && lane_mask[l]) lane = wd3[l*32 +: 32];
      v[l*32 +: 32] = lane;
    end
    if (inst == 0 && addr == 0) v = '0;
    if (!rst) v = '0;
    return v;
  endfunction

  function automatic logic exp_busy(int inst, logic [4:0] addr);
    return rst && pnd[inst][addr];
  endfunction

  function automatic logic [5:0] exp_cnt(int inst);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(pnd[inst][r]);
    return rst ? 6'(n) : 6'd0;
  endfunction

  // Advance one clock edge, applying the inputs present at the edge to the model.
  task automatic tick();
    @(posedge clk);
    for (int inst = 0; inst < 2; inst++) begin
      if (!rst) begin
        for (int r = 0; r < 32; r++) begin
          pnd[inst][r] = 1'b0;
          for (int l = 0; l < 4; l++) mem[inst][r][l] = '0;
        end
      end else begin
        if (we3 && !(inst == 0 && a3 == 0))
          for (int l = 0; l < 4; l++)
            if (lane_mask[l]) mem[inst][a3][l] = wd3[l*32 +: 32];
        if (we3) pnd[inst][a3] = 1'b0;
        if (pend_set && !(inst == 0 && pend_addr == 0)) pnd[inst][pend_addr] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; pend_set = 1'b0; lane_mask = '0; wd3 = '0; a3 = '0; pend_addr = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); a1 = 5; a2 = 5; rst = 1'b1;
    we3 = 1'b1; a3 = 5; lane_mask = 4'hF; wd3 = {4{32'hABCDEFFF}};
    tick(); idle(); #1;
    total++; if (rd1 !== {4{32'hABCDEFFF}}) begin bad++; $display("FAIL rst_prewrite rd1=%h want=%h", rd1, {4{32'hABCDEFFF}}); end
    rst = 1'b0; pend_set = 1'b1; pend_addr = 5; #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL rst_low_rd1 rd1=%h want=0", rd1); end
    total++; if (pend_count !== 6'd0) begin bad++; $display("FAIL rst_low_cnt cnt=%0d want=0", pend_count); end
    tick(); rst = 1'b1; idle(); #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL rst_after_rd1 rd1=%h want=0", rd1); end
    total++; if (pend_count !== 6'd0 || busy1 !== 1'b0) begin bad++; $display("FAIL rst_after_cnt cnt=%0d busy=%b want=0/0", pend_count, busy1); end
  endtask

  task automatic test_masked_write();
    we3 = 1'b1; a3 = 5; lane_mask = 4'hF; wd3 = {4{32'h11111111}};
    tick();
    lane_mask = 4'b0101; wd3 = {4{32'h22222222}};
    tick(); idle(); a1 = 5; a2 = 5; #1;
    total++; if (rd1 !== {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222}) begin bad++; $display("FAIL masked_rd1 rd1=%h want=11111111222222221111111122222222", rd1); end
    total++; if (nb_rd2 !== {32'h11111111, 32'h22222222, 32'h11111111, 32'h22222222}) begin bad++; $display("FAIL masked_nb_rd2 rd2=%h want=11111111222222221111111122222222", nb_rd2); end
  endtask

  task automatic test_bypass();
    a1 = 7; a2 = 7;
    we3 = 1'b1; a3 = 7; lane_mask = 4'hF; wd3 = {4{32'hDEADBEEF}}; #1;
    total++; if (rd1 !== {4{32'hDEADBEEF}}) begin bad++; $display("FAIL bypass_rd1 rd1=%h want=%h", rd1, {4{32'hDEADBEEF}}); end
    total++; if (nb_rd1 !== '0) begin bad++; $display("FAIL nobypass_rd1 rd1=%h want=0", nb_rd1); end
    tick();
    lane_mask = 4'b0011; wd3 = {4{32'hCAFEBABE}}; #1;
    total++; if (rd2 !== {32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFEBABE, 32'hCAFEBABE}) begin bad++; $display("FAIL bypass_partial rd2=%h want=deadbeefdeadbeefcafebabecafebabe", rd2); end
    total++; if (nb_rd2 !== {4{32'hDEADBEEF}}) begin bad++; $display("FAIL nobypass_partial rd2=%h want=%h", nb_rd2, {4{32'hDEADBEEF}}); end
    tick(); idle();
  endtask

  task automatic test_zero_reg();
    a1 = 0; a2 = 0;
    we3 = 1'b1; a3 = 0; lane_mask = 4'hF; wd3 = {128{1'b1}};
    pend_set = 1'b1; pend_addr = 0; #1;
    total++; if (rd1 !== '0) begin bad++; $display("FAIL zero_bypass rd1=%h want=0", rd1); end
    tick(); idle(); #1;
    total++; if (rd1 !== '0 || busy1 !== 1'b0 || pend_count !== 6'd0) begin bad++; $display("FAIL zero_after rd1=%h busy=%b cnt=%0d want=0/0/0", rd1, busy1, pend_count); end
    total++; if (nb_rd1 !== {128{1'b1}} || nb_busy1 !== 1'b1 || nb_pend_count !== 6'd1) begin bad++; $display("FAIL nozero_after rd1=%h busy=%b cnt=%0d want=ones/1/1", nb_rd1, nb_busy1, nb_pend_count); end
    // Mask-free write retires the pending bit without touching data.
    we3 = 1'b1; a3 = 0; lane_mask = 4'h0; wd3 = '0;
    tick(); idle(); #1;
    total++; if (nb_busy1 !== 1'b0 || nb_pend_count !== 6'd0 || nb_rd1 !== {128{1'b1}}) begin bad++; $display("FAIL nozero_clear busy=%b cnt=%0d rd1=%h want=0/0/ones", nb_busy1, nb_pend_count, nb_rd1); end
  endtask

  task automatic test_scoreboard();
    a1 = 3; a2 = 9;
    pend_set = 1'b1; pend_addr = 3; tick();
    #1;
    total++; if (pend_count !== 6'd1) begin bad++; $display("FAIL sb_cnt1 cnt=%0d want=1", pend_count); end
    pend_addr = 9; tick(); idle(); #1;
    total++; if (pend_count !== 6'd2 || busy1 !== 1'b1 || busy2 !== 1'b1) begin bad++; $display("FAIL sb_cnt2 cnt=%0d b1=%b b2=%b want=2/1/1", pend_count, busy1, busy2); end
    we3 = 1'b1; a3 = 3; lane_mask = 4'hF; wd3 = {4{32'h0000_3333}};
    pend_set = 1'b1; pend_addr = 3; #1;
    total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL sb_busy_wrcycle busy1=%b want=1", busy1); end
    tick(); idle(); #1;
    total++; if (busy1 !== 1'b1 || pend_count !== 6'd2) begin bad++; $display("FAIL sb_setwins busy1=%b cnt=%0d want=1/2", busy1, pend_count); end
    we3 = 1'b1; a3 = 9; lane_mask = 4'hF; wd3 = {4{32'h0000_9999}};
    tick(); idle(); #1;
    total++; if (busy2 !== 1'b0 || pend_count !== 6'd1) begin bad++; $display("FAIL sb_retire busy2=%b cnt=%0d want=0/1", busy2, pend_count); end
  endtask

  task automatic test_reset_mid();
    pend_set = 1'b1; pend_addr = 4;
    we3 = 1'b1; a3 = 4; lane_mask = 4'hF; wd3 = {$urandom, $urandom, $urandom, $urandom};
    rst = 1'b0;
    tick(); rst = 1'b1; idle(); a1 = 4; a2 = 3; #1;
    total++; if (rd1 !== '0 || busy1 !== 1'b0) begin bad++; $display("FAIL midrst_reg4 rd1=%h busy=%b want=0/0", rd1, busy1); end
    total++; if (pend_count !== 6'd0 || busy2 !== 1'b0) begin bad++; $display("FAIL midrst_cnt cnt=%0d busy2=%b want=0/0", pend_count, busy2); end
  endtask

  function automatic logic [4:0] rnd_addr();
    return ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
  endfunction

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 40) != 0);
      we3       = $urandom_range(0, 1);
      pend_set  = $urandom_range(0, 2) != 0;
      a1 = rnd_addr(); a2 = rnd_addr(); a3 = rnd_addr(); pend_addr = rnd_addr();
      lane_mask = 4'($urandom);
      wd3       = {$urandom, $urandom, $urandom, $urandom};
      #1;
      total++; if (rd1 !== exp_rd(0, a1)) begin bad++; $display("FAIL rnd_rd1 c=%0d got=%h want=%h", c, rd1, exp_rd(0, a1)); end
      total++; if (rd2 !== exp_rd(0, a2)) begin bad++; $display("FAIL rnd_rd2 c=%0d got=%h want=%h", c, rd2, exp_rd(0, a2)); end
      total++; if (nb_rd1 !== exp_rd(1, a1)) begin bad++; $display("FAIL rnd_nb_rd1 c=%0d got=%h want=%h", c, nb_rd1, exp_rd(1, a1)); end
      total++; if (nb_rd2 !== exp_rd(1, a2)) begin bad++; $display("FAIL rnd_nb_rd2 c=%0d got=%h want=%h", c, nb_rd2, exp_rd(1, a2)); end
      total++; if (busy1 !== exp_busy(0, a1) || busy2 !== exp_busy(0, a2)) begin bad++; $display("FAIL rnd_busy c=%0d got=%b%b want=%b%b", c, busy1, busy2, exp_busy(0, a1), exp_busy(0, a2)); end
      total++; if (nb_busy1 !== exp_busy(1, a1) || nb_busy2 !== exp_busy(1, a2)) begin bad++; $display("FAIL rnd_nb_busy c=%0d got=%b%b want=%b%b", c, nb_busy1, nb_busy2, exp_busy(1, a1), exp_busy(1, a2)); end
      total++; if (pend_count !== exp_cnt(0)) begin bad++; $display("FAIL rnd_cnt c=%0d got=%0d want=%0d", c, pend_count, exp_cnt(0)); end
      total++; if (nb_pend_count !== exp_cnt(1)) begin bad++; $display("FAIL rnd_nb_cnt c=%0d got=%0d want=%0d", c, nb_pend_count, exp_cnt(1)); end
      tick();
    end
    rst = 1'b1; idle();
  endtask

  initial begin
    rst = 1'b0; idle(); a1 = '0; a2 = '0;
    tick(); tick();
    rst = 1'b1;
    test_reset();
    test_masked_write();
    test_bypass();
    test_zero_reg();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout sim_time=%0t limit=200000", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
